// File: rtl/trace_capture_if.sv
// Bundles the probe, trigger-config and readout signals of trace_capture.
// Latency: none, this is wiring only.
// Backpressure: none; readout pops are paced by rd_en alone.
//
// Ports (by direction seen from the capture block, modport slave):
//   in : ch_data, sel, arm, trig_mask, trig_value, post_count, rd_en
//   out: rd_data, rd_valid, armed, done, rd_empty, n_stored
// The driving side (stimulus or debug controller) uses modport master.
interface trace_capture_if #(
    parameter int WIDTH = 32,
    parameter int NCH   = 4,
    parameter int DEPTH = 16
);
    localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [NCH*WIDTH-1:0] ch_data;
    logic [SW-1:0]        sel;
    logic                 arm;
    logic [WIDTH-1:0]     trig_mask;
    logic [WIDTH-1:0]     trig_value;
    logic [AW-1:0]        post_count;
    logic                 rd_en;
    logic [WIDTH-1:0]     rd_data;
    logic                 rd_valid;
    logic                 armed;
    logic                 done;
    logic                 rd_empty;
    logic [CW-1:0]        n_stored;

    modport master (
        output ch_data, sel, arm, trig_mask, trig_value, post_count, rd_en,
        input  rd_data, rd_valid, armed, done, rd_empty, n_stored
    );

    modport slave (
        input  ch_data, sel, arm, trig_mask, trig_value, post_count, rd_en,
        output rd_data, rd_valid, armed, done, rd_empty, n_stored
    );
endinterface

// File: rtl/trace_capture.sv
// Debug trace capture: muxes one of NCH probes, triggers on a masked match, keeps pre/post history.
// Latency: one sample stored per cycle while capturing; a pop returns rd_data one cycle after rd_en.
// Backpressure: none; capture never stalls, rd_en is ignored unless DONE with unread entries.
//
// Ports:
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : trace_capture_if.slave (probe inputs, trigger config, readout outputs)
module trace_capture #(
    parameter int WIDTH = 32,
    parameter int NCH   = 4,
    parameter int DEPTH = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    trace_capture_if.slave  bus
);
    localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    n_stored;
    logic [AW-1:0]    post_left;
    logic [CW-1:0]    rd_cnt;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;

    logic [WIDTH-1:0] sample;
    logic             match;
    logic             wr_en;
    logic             full;
    logic             rd_empty;
    logic             pop;
    logic [AW-1:0]    rd_base;
    logic [AW-1:0]    rd_addr;

    // Probe mux. Out-of-range selects fall back to channel 0 rather than
    // indexing past the packed bus.
    always_comb begin
        sample = bus.ch_data[WIDTH-1:0];
        for (int k = 0; k < NCH; k++) begin
            if (bus.sel == SW'(k)) begin
                sample = bus.ch_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign match = ((sample ^ bus.trig_value) & bus.trig_mask) == '0;

    // ---------------------------------------------------------------
    // Capture FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------------------------------------------------------
    // Capture FSM: next state and write enable.
    // arm overrides everything, including a match in the same cycle; the
    // arm cycle itself stores nothing, the first sample lands one cycle later.
    // ---------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        if (bus.arm) begin
            state_nxt = ARMED;
        end else begin
            case (state)
                ARMED: begin
                    wr_en = 1'b1;
                    if (match) begin
                        state_nxt = (post_left == '0) ? DONE : POST;
                    end
                end
                POST: begin
                    wr_en = 1'b1;
                    // This write consumes the last post-trigger slot.
                    if (post_left == AW'(1)) begin
                        state_nxt = DONE;
                    end
                end
                default: begin
                    state_nxt = state;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Readout addressing. Once the buffer has wrapped, wr_ptr points at the
    // oldest surviving entry; before that the oldest entry is slot 0.
    // rd_cnt counts pops, so the read address is base + pops (mod DEPTH).
    // ---------------------------------------------------------------
    assign full     = (n_stored == CW'(DEPTH));
    assign rd_base  = full ? wr_ptr : '0;
    assign rd_addr  = rd_base + rd_cnt[AW-1:0];
    assign rd_empty = (state == DONE) && (rd_cnt == n_stored);
    assign pop      = (state == DONE) && bus.rd_en && !rd_empty && !bus.arm;

    // Sample storage; contents are don't-care after reset or re-arm.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= sample;
        end
    end

    // ---------------------------------------------------------------
    // Pointers, counters and read port
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            n_stored  <= '0;
            post_left <= '0;
            rd_cnt    <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
        end else if (bus.arm) begin
            wr_ptr    <= '0;
            n_stored  <= '0;
            post_left <= bus.post_count;
            rd_cnt    <= '0;
            rd_valid  <= 1'b0;
        end else begin
            rd_valid <= 1'b0;

            if (wr_en) begin
                // DEPTH is a power of two, so natural wrap of wr_ptr is mod DEPTH.
                wr_ptr <= wr_ptr + AW'(1);
                if (!full) begin
                    n_stored <= n_stored + CW'(1);
                end
            end

            if (state == POST) begin
                post_left <= post_left - AW'(1);
            end

            if (pop) begin
                rd_data  <= mem[rd_addr];
                rd_valid <= 1'b1;
                rd_cnt   <= rd_cnt + CW'(1);
            end
        end
    end

    assign bus.rd_data  = rd_data;
    assign bus.rd_valid = rd_valid;
    assign bus.armed    = (state == ARMED);
    assign bus.done     = (state == DONE);
    assign bus.rd_empty = rd_empty;
    assign bus.n_stored = n_stored;

endmodule
